percept_serial_bus_if: RTL and testbench

Single-wire serial front end serving NUM_CH perceptron channels from one host line. Decodes framed commands (read, write, multiply-accumulate) addressed to one channel or broadcast to all. Streams payload bits into or out of the selected channel's shift register. Successor to the single-channel, fixed-length interface: adds parametrised address width, channel count and payload length, a MAC command, broadcast, and clean skipping of frames addressed elsewhere.

---
 rtl/percept_bus_pkg.sv | 30 +++
 rtl/percept_addr_dec.sv | 48 ++++
 rtl/percept_serial_bus_if.sv | 182 ++++++++++++++++++
 tb/tb_percept_serial_bus_if.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/percept_bus_pkg.sv
// Shared types for the perceptron serial bus front end: FSM states, opcodes
// and header field offsets.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package percept_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        OPCODE,
        TURN,
        WRITE,
        READ,
        SKIP,
        GUARD
    } state_t;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_READ  = 2'b00;
    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
    localparam logic [OP_W-1:0] OP_MAC   = 2'b10;
    localparam logic [OP_W-1:0] OP_RSVD  = 2'b11;

    // The header shift register holds {address, opcode}; the opcode arrives
    // last and therefore lands in the low bits.
    localparam int OPC_OFS  = 0;
    localparam int ADDR_OFS = OP_W;

endpackage

// File: rtl/percept_addr_dec.sv
// Address/opcode decoder: maps a frame address to a channel hit, broadcast
// flag, one-hot channel mask and channel index.
// Latency: combinational. Backpressure: none.
// Ports: addr/opcode in; hit (frame accepted), bcast, mask[NUM_CH], sel out.
module percept_addr_dec
    import percept_bus_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          NUM_CH    = 4,
    parameter int unsigned BASE_ADDR = 'h10,
    parameter bit          BCAST_EN  = 1'b1,
    localparam int         SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [OP_W-1:0]   opcode,
    output logic              hit,
    output logic              bcast,
    output logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  sel
);

    // Channel window must not wrap past the top of the address space.
    if (longint'(BASE_ADDR) + NUM_CH - 1 >= (longint'(1) << ADDR_W)) begin : g_range_chk
        $error("percept_addr_dec: BASE_ADDR+NUM_CH-1 does not fit in ADDR_W bits");
    end

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BASE_ADDR + NUM_CH - 1);

    logic in_range;

    always_comb begin
        in_range = (addr >= FIRST) && (addr <= LAST);
        // A real channel sitting at the all-ones address wins over broadcast.
        bcast    = BCAST_EN && (&addr) && !in_range;
        sel      = in_range ? SEL_W'(addr - FIRST) : '0;
        // Broadcast is only meaningful for commands that fan data in.
        hit      = in_range || (bcast && (opcode == OP_WRITE || opcode == OP_MAC));
        mask     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            mask[k] = in_range && (sel == SEL_W'(k));
        end
        if (bcast) begin
            mask = '1;
        end
    end

endmodule

// File: rtl/percept_serial_bus_if.sv
// Single-wire framed command front end for NUM_CH perceptron channels.
// Latency: outputs registered, one cycle after the sampling edge.
// Backpressure: none; the host line is free-running, frames for other
// addresses are skipped by length.
// Ports: clk/rst; in = host line; data_out = per-channel read bits;
// shift_in/shift_out/mul_and_acc = per-channel strobes; data_in = shared write
// bit; out = read bit to host; busy = frame in progress; cmd_err = reserved op.
module percept_serial_bus_if
    import percept_bus_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter int          NUM_CH       = 4,
    parameter int unsigned BASE_ADDR    = 'h10,
    parameter int          PAYLOAD_BITS = 72,
    parameter bit          BCAST_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic [NUM_CH-1:0] data_out,
    output logic [NUM_CH-1:0] shift_in,
    output logic [NUM_CH-1:0] shift_out,
    output logic [NUM_CH-1:0] mul_and_acc,
    output logic              data_in,
    output logic              out,
    output logic              busy,
    output logic              cmd_err
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HDR_W = ADDR_W + OP_W;
    localparam int HC_W  = $clog2(HDR_W + 1);
    localparam int PC_W  = $clog2(PAYLOAD_BITS + 1);

    state_t            state, state_nxt;
    logic [HDR_W-1:0]  hdr, hdr_nxt;
    logic [HC_W-1:0]   hdr_cnt, hdr_cnt_nxt;
    logic [PC_W-1:0]   pay_cnt, pay_cnt_nxt;
    logic [NUM_CH-1:0] mask_q, mask_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;

    logic [NUM_CH-1:0] shift_in_nxt, shift_out_nxt, mac_nxt;
    logic              data_in_nxt, out_nxt, cmd_err_nxt;

    logic [OP_W-1:0]   cur_op;
    logic              dec_hit, dec_bcast;
    logic [NUM_CH-1:0] dec_mask;
    logic [SEL_W-1:0]  dec_sel;
    logic              pay_last;

    assign cur_op   = hdr[OPC_OFS +: OP_W];
    assign pay_last = (pay_cnt == PC_W'(PAYLOAD_BITS - 1));
    assign busy     = (state != IDLE);

    percept_addr_dec #(
        .ADDR_W    (ADDR_W),
        .NUM_CH    (NUM_CH),
        .BASE_ADDR (BASE_ADDR),
        .BCAST_EN  (BCAST_EN)
    ) u_dec (
        .addr   (hdr[ADDR_OFS +: ADDR_W]),
        .opcode (cur_op),
        .hit    (dec_hit),
        .bcast  (dec_bcast),
        .mask   (dec_mask),
        .sel    (dec_sel)
    );

    always_comb begin
        state_nxt     = state;
        hdr_nxt       = hdr;
        hdr_cnt_nxt   = hdr_cnt;
        pay_cnt_nxt   = pay_cnt;
        mask_nxt      = mask_q;
        sel_nxt       = sel_q;
        shift_in_nxt  = '0;
        shift_out_nxt = '0;
        mac_nxt       = '0;
        data_in_nxt   = 1'b0;
        out_nxt       = 1'b0;
        cmd_err_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (!in) begin
                    state_nxt   = ADDR;
                    hdr_cnt_nxt = '0;
                end
            end
            ADDR, OPCODE: begin
                // One counter spans address and opcode bits.
                hdr_nxt     = {hdr[HDR_W-2:0], in};
                hdr_cnt_nxt = hdr_cnt + 1'b1;
                if (state == ADDR && hdr_cnt == HC_W'(ADDR_W - 1)) begin
                    state_nxt = OPCODE;
                end
                if (state == OPCODE && hdr_cnt == HC_W'(HDR_W - 1)) begin
                    state_nxt = TURN;
                end
            end
            TURN: begin
                pay_cnt_nxt = '0;
                mask_nxt    = dec_mask;
                sel_nxt     = dec_sel;
                if (cur_op == OP_RSVD) begin
                    cmd_err_nxt = 1'b1;
                    state_nxt   = SKIP;
                end else if (!dec_hit) begin
                    state_nxt = SKIP;
                end else if (cur_op == OP_WRITE) begin
                    state_nxt = WRITE;
                end else if (cur_op == OP_READ && !dec_bcast) begin
                    // Read strobe leads the payload window by one cycle so
                    // the first bit is already on data_out at the first edge.
                    shift_out_nxt = dec_mask;
                    state_nxt     = READ;
                end else if (cur_op == OP_MAC) begin
                    mac_nxt   = dec_mask;
                    state_nxt = GUARD;
                end else begin
                    state_nxt = SKIP;
                end
            end
            WRITE: begin
                shift_in_nxt = mask_q;
                data_in_nxt  = in;
                pay_cnt_nxt  = pay_cnt + 1'b1;
                if (pay_last) state_nxt = GUARD;
            end
            READ: begin
                out_nxt     = data_out[sel_q];
                pay_cnt_nxt = pay_cnt + 1'b1;
                if (pay_last) begin
                    state_nxt = GUARD;
                end else begin
                    shift_out_nxt = mask_q;
                end
            end
            SKIP: begin
                // Line content is ignored here so payload zeros never
                // look like a start bit.
                pay_cnt_nxt = pay_cnt + 1'b1;
                if (pay_last) state_nxt = GUARD;
            end
            GUARD: begin
                if (in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hdr         <= '0;
            hdr_cnt     <= '0;
            pay_cnt     <= '0;
            mask_q      <= '0;
            sel_q       <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            mul_and_acc <= '0;
            data_in     <= 1'b0;
            out         <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            hdr         <= hdr_nxt;
            hdr_cnt     <= hdr_cnt_nxt;
            pay_cnt     <= pay_cnt_nxt;
            mask_q      <= mask_nxt;
            sel_q       <= sel_nxt;
            shift_in    <= shift_in_nxt;
            shift_out   <= shift_out_nxt;
            mul_and_acc <= mac_nxt;
            data_in     <= data_in_nxt;
            out         <= out_nxt;
            cmd_err     <= cmd_err_nxt;
        end
    end

endmodule

// File: tb/tb_percept_serial_bus_if.sv
// Scoreboard bench for percept_serial_bus_if: frames are expanded into a
// per-cycle expected output trace, a monitor compares whenever the DUT is
// busy or drives anything.
module tb_percept_serial_bus_if;

    localparam int A    = 8;
    localparam int NCH  = 4;
    localparam int PB   = 72;
    localparam int BASE = 'h10;
    localparam int P    = A + 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           line_in;
    logic [NCH-1:0] data_out;
    logic [NCH-1:0] shift_in, shift_out, mul_and_acc;
    logic           data_in, ser_out, busy, cmd_err;

    always #5 clk = ~clk;

    percept_serial_bus_if #(
        .ADDR_W       (A),
        .NUM_CH       (NCH),
        .BASE_ADDR    (BASE),
        .PAYLOAD_BITS (PB),
        .BCAST_EN     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (line_in),
        .data_out    (data_out),
        .shift_in    (shift_in),
        .shift_out   (shift_out),
        .mul_and_acc (mul_and_acc),
        .data_in     (data_in),
        .out         (ser_out),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    typedef struct packed {
        logic           busy;
        logic [NCH-1:0] si;
        logic [NCH-1:0] so;
        logic [NCH-1:0] mac;
        logic           err;
        logic           din;
        logic           dout;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   rec_n = 0;
    bit   mon_en = 1'b0;

    function automatic rec_t sample_dut();
        rec_t g;
        g.busy = busy;
        g.si   = shift_in;
        g.so   = shift_out;
        g.mac  = mul_and_acc;
        g.err  = cmd_err;
        g.din  = data_in;
        g.dout = ser_out;
        return g;
    endfunction

    // Monitor: every cycle with any DUT activity consumes one expected record.
    initial begin
        rec_t g, e;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            g = sample_dut();
            if (g !== '0) begin
                total++;
                rec_n++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_activity rec#%0d: got busy=%b si=%b so=%b mac=%b err=%b din=%b out=%b, want idle",
                             rec_n, g.busy, g.si, g.so, g.mac, g.err, g.din, g.dout);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        bad++;
                        $display("FAIL cycle_rec rec#%0d: got busy=%b si=%b so=%b mac=%b err=%b din=%b out=%b, want busy=%b si=%b so=%b mac=%b err=%b din=%b out=%b",
                                 rec_n, g.busy, g.si, g.so, g.mac, g.err, g.din, g.dout,
                                 e.busy, e.si, e.so, e.mac, e.err, e.din, e.dout);
                    end
                end
            end
        end
    end

    // Builds the line waveform for one frame, pushes the expected per-cycle
    // outputs derived from the frame timing rules, then drives the line.
    // rst_at >= 0 pulses rst so that it is sampled at that frame cycle.
    task automatic send_frame(input logic [A-1:0] addr, input logic [1:0] op,
                              input logic [PB-1:0] pay, input int gap0,
                              input int idle1, input int rst_at);
        logic [NCH-1:0] mask;
        int             sel;
        bit             wr, rd, mac;
        int             last;
        logic           line[$];
        logic [NCH-1:0] dv[$];
        rec_t           r;

        mask = '0;
        sel  = 0;
        if (int'(addr) >= BASE && int'(addr) < BASE + NCH) begin
            sel  = int'(addr) - BASE;
            mask = NCH'(1) << sel;
        end else if (addr == 8'hFF && (op == 2'b01 || op == 2'b10)) begin
            mask = '1;
        end
        wr  = (mask != 0) && (op == 2'b01);
        rd  = (mask != 0) && (op == 2'b00);
        mac = (mask != 0) && (op == 2'b10);

        line.push_back(1'b0);
        for (int i = A - 1; i >= 0; i--) line.push_back(addr[i]);
        line.push_back(op[1]);
        line.push_back(op[0]);
        line.push_back(1'($urandom));
        if (!mac) for (int i = PB - 1; i >= 0; i--) line.push_back(pay[i]);
        if (rst_at >= 0) begin
            while (line.size() > rst_at) void'(line.pop_back());
            line.push_back(1'b1);
        end else begin
            repeat (gap0) line.push_back(1'b0);
        end
        repeat (idle1) line.push_back(1'b1);
        for (int c = 0; c < line.size(); c++) dv.push_back(NCH'($urandom));

        last = (mac ? P - 1 : P + PB - 1) + gap0;
        if (rst_at >= 0) last = rst_at - 1;
        for (int c = 0; c <= last; c++) begin
            r      = '0;
            r.busy = 1'b1;
            if (wr && c >= P && c < P + PB) begin
                r.si  = mask;
                r.din = line[c];
            end
            if (rd && c >= P - 1 && c <= P + PB - 2) r.so = mask;
            if (rd && c >= P && c < P + PB) r.dout = dv[c][sel];
            if (mac && c == P - 1) r.mac = mask;
            if (op == 2'b11 && c == P - 1) r.err = 1'b1;
            exp_q.push_back(r);
        end

        for (int c = 0; c < line.size(); c++) begin
            @(negedge clk);
            line_in  = line[c];
            data_out = dv[c];
            rst      = (c == rst_at);
        end
    endtask

    initial begin
        rec_t         g;
        logic [A-1:0] ad;
        logic [PB-1:0] pr;
        int           k;

        rst      = 1'b1;
        line_in  = 1'b1;
        data_out = '0;
        repeat (3) @(negedge clk);
        g = sample_dut();
        total++;
        if (g !== '0) begin
            bad++;
            $display("FAIL reset_state: got %b, want all zero", g);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        pr = {8'($urandom), $urandom, $urandom};
        send_frame(8'h12, 2'b01, {9{8'hA5}}, 0, 2, -1);   // write channel 2
        send_frame(8'h11, 2'b00, pr, 0, 1, -1);           // read channel 1
        send_frame(8'hFF, 2'b10, '0, 2, 1, -1);           // broadcast MAC
        send_frame(8'h40, 2'b01, '0, 3, 1, -1);           // miss, zero payload
        send_frame(8'h10, 2'b11, pr, 0, 1, -1);           // reserved opcode
        send_frame(8'hFF, 2'b00, pr, 1, 1, -1);           // broadcast read skipped
        send_frame(8'hFF, 2'b01, pr, 0, 1, -1);           // broadcast write
        send_frame(8'h13, 2'b01, pr, 0, 2, P + 30);       // reset mid-payload
        send_frame(8'h13, 2'b01, ~pr, 0, 1, -1);
        send_frame(8'h10, 2'b10, '0, 0, 1, -1);           // MAC channel 0

        for (int n = 0; n < 24; n++) begin
            k  = $urandom_range(0, 5);
            ad = (k < 4) ? A'(BASE + k) : (k == 4) ? 8'hFF : A'($urandom);
            pr = {8'($urandom), $urandom, $urandom};
            send_frame(ad, 2'($urandom), pr, $urandom_range(0, 3), $urandom_range(1, 3), -1);
        end

        repeat (6) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d records unconsumed, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
